// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - multi-lane registered immediate/target generator
// with a two-entry (MAIN + SKID) valid/ready buffer and synchronous flush.
module imm_gen_pipe #(
    parameter int XLEN      = 32,
    parameter int LANES     = 2,
    parameter int I21_SHIFT = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES-1:0]      in_lane_valid,
    input  logic [LANES*32-1:0]   in_instr,
    input  logic [LANES*3-1:0]    in_itype,
    input  logic [LANES-1:0]      in_unsign,
    input  logic [LANES*XLEN-1:0] in_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES-1:0]      out_lane_valid,
    output logic [LANES*XLEN-1:0] out_imm,
    output logic [LANES*XLEN-1:0] out_target
);

    // bit0 = MAIN full, bit1 = SKID full, so both handshake outputs come straight off flops
    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_ONE   = 2'b01,
        S_FULL  = 2'b11
    } state_t;

    state_t state, state_nxt;

    logic accept, drain;
    logic load_main_in, load_main_skid, load_skid;

    logic [LANES*XLEN-1:0] nxt_imm, nxt_target;
    logic [LANES-1:0]      unused_hi;

    logic [LANES-1:0]      main_lane_valid, skid_lane_valid;
    logic [LANES*XLEN-1:0] main_imm, skid_imm;
    logic [LANES*XLEN-1:0] main_target, skid_target;

    function automatic logic [XLEN-1:0] calc_imm(input logic [25:0] ins,
                                                 input logic [2:0]  itype,
                                                 input logic        uns);
        case (itype)
            3'd0: return (XLEN == 32) ? {{(XLEN-5){1'b0}}, ins[14:10]}
                                      : {{(XLEN-6){1'b0}}, ins[15:10]};
            3'd1: return {{(XLEN-12){~uns & ins[21]}}, ins[21:10]};
            3'd2: return {{(XLEN-16){ins[23]}}, ins[23:10], 2'b00};
            3'd3: return {{(XLEN-18){ins[25]}}, ins[25:10], 2'b00};
            3'd4: return {{(XLEN-31){ins[24]}}, ins[23:5], 12'h000};
            3'd5: return {{(XLEN-21){ins[4]}}, ins[4:0], ins[25:10]} << I21_SHIFT;
            3'd6: return {{(XLEN-28){ins[9]}}, ins[9:0], ins[25:10], 2'b00};
            default: return '0;
        endcase
    endfunction

    always_comb begin
        nxt_imm    = '0;
        nxt_target = '0;
        unused_hi  = '0;
        for (int i = 0; i < LANES; i++) begin
            unused_hi[i] = ^in_instr[i*32+26 +: 6];
            if (in_lane_valid[i])
                nxt_imm[i*XLEN +: XLEN] = calc_imm(in_instr[i*32 +: 26], in_itype[i*3 +: 3],
                                                   in_unsign[i]);
            nxt_target[i*XLEN +: XLEN] = in_pc[i*XLEN +: XLEN] + nxt_imm[i*XLEN +: XLEN];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_EMPTY;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_EMPTY: if (accept) state_nxt = S_ONE;
            S_ONE: begin
                if (accept && !drain)
                    state_nxt = S_FULL;
                else if (!accept && drain)
                    state_nxt = S_EMPTY;
            end
            S_FULL:  if (drain) state_nxt = S_ONE;
            default: state_nxt = S_EMPTY;
        endcase
        if (flush)
            state_nxt = S_EMPTY;
    end

    always_comb begin
        in_ready       = ~state[1];
        out_valid      = state[0];
        accept         = in_valid & ~state[1] & ~flush;
        drain          = state[0] & out_ready;
        load_main_in   = accept & ((state == S_EMPTY) | ((state == S_ONE) & drain));
        load_skid      = accept & (state == S_ONE) & ~drain;
        load_main_skid = ~flush & (state == S_FULL) & drain;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_lane_valid <= '0;
            main_imm        <= '0;
            main_target     <= '0;
            skid_lane_valid <= '0;
            skid_imm        <= '0;
            skid_target     <= '0;
        end else begin
            if (load_skid) begin
                skid_lane_valid <= in_lane_valid;
                skid_imm        <= nxt_imm;
                skid_target     <= nxt_target;
            end
            if (load_main_in) begin
                main_lane_valid <= in_lane_valid;
                main_imm        <= nxt_imm;
                main_target     <= nxt_target;
            end else if (load_main_skid) begin
                main_lane_valid <= skid_lane_valid;
                main_imm        <= skid_imm;
                main_target     <= skid_target;
            end
        end
    end

    assign out_lane_valid = main_lane_valid;
    assign out_imm        = main_imm;
    assign out_target     = main_target;

    property p_hold_stable;
        @(posedge clk) disable iff (rst)
        (out_valid && !out_ready && !flush) |=>
            (out_valid && $stable(out_lane_valid) && $stable(out_imm) && $stable(out_target));
    endproperty
    a_hold_stable: assert property (p_hold_stable);

    a_ready_implies_valid: assert property (@(posedge clk) disable iff (rst) !in_ready |-> out_valid);

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - randomized and directed bench for imm_gen_pipe
// (XLEN=32/LANES=2 main instance, XLEN=64/LANES=1/I21_SHIFT=2 wide instance).
module tb_imm_gen_pipe;

    localparam int X  = 32;
    localparam int L  = 2;
    localparam int EW = L + 2*L*X;

    typedef struct packed {
        logic [L-1:0]   lv;
        logic [L*32-1:0] instr;
        logic [L*3-1:0]  itype;
        logic [L-1:0]    uns;
        logic [L*X-1:0]  pc;
    } bundle_t;

    logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [L-1:0]    in_lane_valid = '0, in_unsign = '0;
    logic [L*32-1:0] in_instr = '0;
    logic [L*3-1:0]  in_itype = '0;
    logic [L*X-1:0]  in_pc = '0;
    logic            in_ready, out_valid;
    logic [L-1:0]    out_lane_valid;
    logic [L*X-1:0]  out_imm, out_target;
    logic [EW-1:0]   obs;

    logic        flush_w = 1'b0, in_valid_w = 1'b0, out_ready_w = 1'b1;
    logic [0:0]  lv_w = '0, uns_w = '0;
    logic [31:0] instr_w = '0;
    logic [2:0]  itype_w = '0;
    logic [63:0] pc_w = '0;
    logic        in_ready_w, out_valid_w;
    logic [0:0]  out_lv_w;
    logic [63:0] out_imm_w, out_tgt_w;

    int n_cmp = 0;
    int n_fail = 0;

    imm_gen_pipe #(.XLEN(X), .LANES(L), .I21_SHIFT(0)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_lane_valid(in_lane_valid), .in_instr(in_instr), .in_itype(in_itype),
        .in_unsign(in_unsign), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_lane_valid(out_lane_valid), .out_imm(out_imm), .out_target(out_target)
    );

    imm_gen_pipe #(.XLEN(64), .LANES(1), .I21_SHIFT(2)) dut_w (
        .clk(clk), .rst(rst), .flush(flush_w),
        .in_valid(in_valid_w), .in_ready(in_ready_w),
        .in_lane_valid(lv_w), .in_instr(instr_w), .in_itype(itype_w),
        .in_unsign(uns_w), .in_pc(pc_w),
        .out_valid(out_valid_w), .out_ready(out_ready_w),
        .out_lane_valid(out_lv_w), .out_imm(out_imm_w), .out_target(out_tgt_w)
    );

    assign obs = {out_lane_valid, out_imm, out_target};

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    // Reference model: field extraction and two's-complement wrap with plain integers.
    function automatic longint field(logic [31:0] ins, int lo, int w);
        return longint'({32'b0, ins} >> lo) % (longint'(1) << w);
    endfunction

    function automatic longint sext(longint v, int w);
        return (v >= (longint'(1) << (w - 1))) ? v - (longint'(1) << w) : v;
    endfunction

    function automatic logic [63:0] ref_imm(logic [31:0] ins, logic [2:0] t, logic u, int xl, int sh);
        longint v;
        case (t)
            3'd0: v = field(ins, 10, (xl == 32) ? 5 : 6);
            3'd1: v = u ? field(ins, 10, 12) : sext(field(ins, 10, 12), 12);
            3'd2: v = sext(field(ins, 10, 14) * 4, 16);
            3'd3: v = sext(field(ins, 10, 16) * 4, 18);
            3'd4: v = sext(field(ins, 5, 20) * 4096, 32);
            3'd5: v = sext(field(ins, 0, 5) * 65536 + field(ins, 10, 16), 21) * (longint'(1) << sh);
            3'd6: v = sext((field(ins, 0, 10) * 65536 + field(ins, 10, 16)) * 4, 28);
            default: v = 0;
        endcase
        return v;
    endfunction

    function automatic logic [EW-1:0] expect_of(bundle_t b);
        logic [L*X-1:0] im, tg;
        logic [63:0]    v;
        for (int i = 0; i < L; i++) begin
            v = b.lv[i] ? ref_imm(b.instr[i*32 +: 32], b.itype[i*3 +: 3], b.uns[i], X, 0) : 64'd0;
            im[i*X +: X] = v[X-1:0];
            tg[i*X +: X] = b.pc[i*X +: X] + v[X-1:0];
        end
        return {b.lv, im, tg};
    endfunction

    function automatic bundle_t rand_bundle();
        bundle_t b;
        b.lv    = L'($urandom);
        b.instr = {$urandom, $urandom};
        b.itype = (L*3)'($urandom);
        b.uns   = L'($urandom);
        b.pc    = {$urandom, $urandom};
        return b;
    endfunction

    task automatic drive(input bundle_t b);
        in_lane_valid = b.lv;
        in_instr      = b.instr;
        in_itype      = b.itype;
        in_unsign     = b.uns;
        in_pc         = b.pc;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_flags: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
        end
        n_cmp++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %h, required 0", obs);
        end
        n_cmp++;
        if (out_valid_w !== 1'b0 || in_ready_w !== 1'b1 || out_imm_w !== 64'd0 || out_tgt_w !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_wide: valid=%b ready=%b imm=%h tgt=%h, required 0/1/0/0",
                     out_valid_w, in_ready_w, out_imm_w, out_tgt_w);
        end
    endtask

    task automatic test_directed();
        bundle_t     b[3];
        logic [63:0] ei[3], et[3];
        logic [1:0]  el[3];
        b[0] = '{lv: 2'b11, instr: {32'h003FFC00, 32'h003FFC00}, itype: {3'd1, 3'd1},
                 uns: 2'b10, pc: {32'h00002000, 32'h00001000}};
        el[0] = 2'b11; ei[0] = {32'h00000FFF, 32'hFFFFFFFF}; et[0] = {32'h00002FFF, 32'h00000FFF};
        b[1] = '{lv: 2'b11, instr: {32'h03FFFFFF, 32'h02000000}, itype: {3'd6, 3'd3},
                 uns: 2'b00, pc: {32'h1C000010, 32'h1C000000}};
        el[1] = 2'b11; ei[1] = {32'hFFFFFFFC, 32'hFFFE0000}; et[1] = {32'h1C00000C, 32'h1BFE0000};
        b[2] = '{lv: 2'b01, instr: {32'h03FFFFFF, 32'h00000000}, itype: {3'd6, 3'd7},
                 uns: 2'b00, pc: {32'h1C000010, 32'h00000400}};
        el[2] = 2'b01; ei[2] = 64'd0; et[2] = {32'h1C000010, 32'h00000400};
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(b[k]);
            in_valid = 1'b1;
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL dir%0d_pre: out_valid=%b before accept, required 0", k, out_valid);
            end
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            n_cmp++;
            if (out_valid !== 1'b1 || obs !== {el[k], ei[k], et[k]}) begin
                n_fail++;
                $display("FAIL dir%0d: valid=%b data=%h, required 1 %h", k, out_valid, obs,
                         {el[k], ei[k], et[k]});
            end
        end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        bundle_t a, b, c;
        a = rand_bundle(); b = rand_bundle(); c = rand_bundle();
        out_ready = 1'b0;
        @(negedge clk);
        drive(a); in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || obs !== expect_of(a)) begin
            n_fail++;
            $display("FAIL bp_A: ready=%b data=%h, required 1 %h", in_ready, obs, expect_of(a));
        end
        drive(b);
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || obs !== expect_of(a)) begin
            n_fail++;
            $display("FAIL bp_full: ready=%b valid=%b data=%h, required 0 1 %h",
                     in_ready, out_valid, obs, expect_of(a));
        end
        drive(c); out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || obs !== expect_of(b)) begin
            n_fail++;
            $display("FAIL bp_B: valid=%b data=%h, required 1 %h", out_valid, obs, expect_of(b));
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || obs !== expect_of(c)) begin
            n_fail++;
            $display("FAIL bp_C: valid=%b data=%h, required 1 %h", out_valid, obs, expect_of(c));
        end
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_end: valid=%b ready=%b, required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_flush();
        bundle_t a, c, d;
        a = rand_bundle(); c = rand_bundle(); d = rand_bundle();
        out_ready = 1'b0;
        @(negedge clk);
        drive(a); in_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        drive(c); flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_state: valid=%b ready=%b, required 0 1", out_valid, in_ready);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_no_ghost: valid=%b, required 0", out_valid);
        end
        drive(d); in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || obs !== expect_of(d)) begin
            n_fail++;
            $display("FAIL flush_after: valid=%b data=%h, required 1 %h", out_valid, obs, expect_of(d));
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [EW-1:0] q[$];
        bundle_t       b;
        bit            acc, drn;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin
                n_fail++;
                $display("FAIL rand_flags cyc %0d: valid=%b ready=%b, required occupancy %0d",
                         cyc, out_valid, in_ready, q.size());
            end
            if (q.size() > 0) begin
                n_cmp++;
                if (obs !== q[0]) begin
                    n_fail++;
                    $display("FAIL rand_data cyc %0d: got %h, required %h", cyc, obs, q[0]);
                end
            end
            b = rand_bundle();
            drive(b);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            acc = in_valid && (q.size() < 2) && !flush;
            drn = out_ready && (q.size() > 0);
            @(posedge clk);
            if (flush) begin
                q.delete();
            end else begin
                if (drn) void'(q.pop_front());
                if (acc) q.push_back(expect_of(b));
            end
        end
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        bundle_t a, e;
        a = rand_bundle(); e = rand_bundle();
        out_ready = 1'b0;
        @(negedge clk);
        drive(a); in_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_pre: valid=%b ready=%b, required 1 0", out_valid, in_ready);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || obs !== '0) begin
            n_fail++;
            $display("FAIL rstmid_async: valid=%b ready=%b data=%h, required 0 1 0",
                     out_valid, in_ready, obs);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(e); in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1 || obs !== expect_of(e)) begin
            n_fail++;
            $display("FAIL rstmid_after: valid=%b ready=%b data=%h, required 1 1 %h",
                     out_valid, in_ready, obs, expect_of(e));
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_wide();
        logic [31:0] ins;
        logic [2:0]  t;
        logic [0:0]  lv;
        logic [63:0] pc, ei, et;
        for (int k = 0; k < 32; k++) begin
            if (k == 0) begin
                ins = 32'h01000000; t = 3'd4; lv = 1'b1; pc = 64'h100;
                ei = 64'hFFFFFFFF80000000; et = 64'hFFFFFFFF80000100;
            end else if (k == 1) begin
                ins = 32'h0000FC00; t = 3'd0; lv = 1'b1; pc = 64'h100;
                ei = 64'h3F; et = 64'h13F;
            end else begin
                ins = $urandom; t = 3'($urandom); lv = 1'($urandom_range(0, 4) != 0);
                pc = {$urandom, $urandom};
                ei = lv[0] ? ref_imm(ins, t, 1'b0, 64, 2) : 64'd0;
                et = pc + ei;
            end
            @(negedge clk);
            instr_w = ins; itype_w = t; lv_w = lv; uns_w = 1'b0; pc_w = pc; in_valid_w = 1'b1;
            @(posedge clk);
            @(negedge clk);
            in_valid_w = 1'b0;
            n_cmp++;
            if (out_valid_w !== 1'b1 || out_lv_w !== lv || out_imm_w !== ei || out_tgt_w !== et) begin
                n_fail++;
                $display("FAIL wide%0d: valid=%b imm=%h tgt=%h, required 1 %h %h",
                         k, out_valid_w, out_imm_w, out_tgt_w, ei, et);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_flush();
        test_random();
        test_reset_mid();
        test_wide();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
